// File: rtl/memory_req_arbiter.sv
// N-to-1 memory request arbiter: picks one requester (round-robin or fixed
// priority), latches its request, holds it on the server port until the
// server fulfills it, then steers the completion pulse back to that requester.

package memory_req_arbiter_pkg;
    typedef enum logic [1:0] {
        MEM_OP_LOAD  = 2'd0,
        MEM_OP_STORE = 2'd1,
        MEM_OP_AMO   = 2'd2,
        MEM_OP_FENCE = 2'd3
    } memory_operation_e;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE   = 2'd0,
        MEM_SIZE_HALF   = 2'd1,
        MEM_SIZE_WORD   = 2'd2,
        MEM_SIZE_DOUBLE = 2'd3
    } memory_operation_size_e;
endpackage

// state | meaning
// IDLE  | no outstanding request; arbitrate among valid requesters
// BUSY  | latched request presented to server, waiting for fulfilled
module memory_req_arbiter
    import memory_req_arbiter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REQ  = 2,
    parameter int ARB_MODE = 0,
    localparam int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ*XLEN-1:0] up_req_address,
    input  memory_operation_e      up_req_operation [NUM_REQ],
    input  memory_operation_size_e up_req_size [NUM_REQ],
    input  logic [NUM_REQ*XLEN-1:0] up_req_store_word,
    input  logic [NUM_REQ-1:0]     up_req_valid,
    output logic [XLEN-1:0]        up_req_loaded_word,
    output logic [NUM_REQ-1:0]     up_req_fulfilled,
    output logic [XLEN-1:0]        mem_req_address,
    output memory_operation_e      mem_req_operation,
    output memory_operation_size_e mem_req_size,
    output logic [XLEN-1:0]        mem_req_store_word,
    output logic                   mem_req_valid,
    input  logic [XLEN-1:0]        mem_req_loaded_word,
    input  logic                   mem_req_fulfilled,
    output logic [IDXW-1:0]        grant_idx,
    output logic                   busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]        grant_idx_q, grant_idx_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    memory_operation_e      op_q, op_d;
    memory_operation_size_e size_q, size_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;

    logic                   found;
    logic [IDXW-1:0]        win_idx;
    logic [IDXW-1:0]        cand;

    // Winner search: walk channels starting at rr_ptr (round-robin) or 0 (fixed priority)
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = (ARB_MODE == 0) ? rr_ptr_q : '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && up_req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
            cand = (cand == IDXW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // Next-state logic: latch the winner in IDLE, release on fulfilled in BUSY
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        addr_d      = addr_q;
        op_d        = op_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = BUSY;
                    grant_idx_d = win_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (IDXW'(i) == win_idx) begin
                            addr_d  = up_req_address[i*XLEN +: XLEN];
                            op_d    = up_req_operation[i];
                            size_d  = up_req_size[i];
                            wdata_d = up_req_store_word[i*XLEN +: XLEN];
                        end
                    end
                end
            end
            BUSY: begin
                if (mem_req_fulfilled) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_idx_q == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion pulse steered to the owning channel only while BUSY
    always_comb begin
        up_req_fulfilled = '0;
        if (state_q == BUSY && mem_req_fulfilled) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (IDXW'(i) == grant_idx_q) begin
                    up_req_fulfilled[i] = 1'b1;
                end
            end
        end
    end

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            addr_q      <= '0;
            op_q        <= MEM_OP_LOAD;
            size_q      <= MEM_SIZE_BYTE;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
        end
    end

    assign mem_req_address    = addr_q;
    assign mem_req_operation  = op_q;
    assign mem_req_size       = size_q;
    assign mem_req_store_word = wdata_q;
    assign mem_req_valid      = (state_q == BUSY);
    assign busy               = (state_q == BUSY);
    assign grant_idx          = grant_idx_q;
    assign up_req_loaded_word = mem_req_loaded_word;

endmodule

// File: tb/tb_memory_req_arbiter.sv
// Bench for memory_req_arbiter: a 4-channel round-robin instance, a 4-channel
// fixed-priority instance and a 2-channel instance, driven by a vector table
// plus hand sequences; completions are checked against a scoreboard queue.
module tb_memory_req_arbiter;
    import memory_req_arbiter_pkg::*;

    typedef struct {
        logic [3:0]  onehot;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int         d;
        logic [3:0] mask;
        int         exp;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // shared request fields for the two 4-channel instances
    logic [127:0]           addr_tb;
    logic [127:0]           store_tb;
    memory_operation_e      op_tb [4];
    memory_operation_size_e size_tb [4];
    logic [31:0]            rdata;

    logic [3:0]             valid [2];
    logic                   f [2];
    logic [3:0]             ful_o [2];
    logic [31:0]            lw_o [2];
    logic [31:0]            maddr_o [2];
    memory_operation_e      mop_o [2];
    memory_operation_size_e msize_o [2];
    logic [31:0]            mstore_o [2];
    logic                   mvalid_o [2];
    logic [1:0]             grant_o [2];
    logic                   busy_o [2];

    // two-channel instance signals
    logic [63:0]            addr_c, store_c;
    memory_operation_e      op_c [2];
    memory_operation_size_e size_c [2];
    logic [1:0]             valid_c;
    logic [31:0]            lw_c, maddr_c, mstore_c, rdata_c;
    logic [1:0]             ful_c;
    memory_operation_e      mop_c;
    memory_operation_size_e msize_c;
    logic                   mvalid_c, f_c, busy_c;
    logic [0:0]             grant_c;

    memory_req_arbiter #(.XLEN(32), .NUM_REQ(4), .ARB_MODE(0)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .up_req_address(addr_tb), .up_req_operation(op_tb), .up_req_size(size_tb),
        .up_req_store_word(store_tb), .up_req_valid(valid[0]),
        .up_req_loaded_word(lw_o[0]), .up_req_fulfilled(ful_o[0]),
        .mem_req_address(maddr_o[0]), .mem_req_operation(mop_o[0]), .mem_req_size(msize_o[0]),
        .mem_req_store_word(mstore_o[0]), .mem_req_valid(mvalid_o[0]),
        .mem_req_loaded_word(rdata), .mem_req_fulfilled(f[0]),
        .grant_idx(grant_o[0]), .busy(busy_o[0])
    );

    memory_req_arbiter #(.XLEN(32), .NUM_REQ(4), .ARB_MODE(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .up_req_address(addr_tb), .up_req_operation(op_tb), .up_req_size(size_tb),
        .up_req_store_word(store_tb), .up_req_valid(valid[1]),
        .up_req_loaded_word(lw_o[1]), .up_req_fulfilled(ful_o[1]),
        .mem_req_address(maddr_o[1]), .mem_req_operation(mop_o[1]), .mem_req_size(msize_o[1]),
        .mem_req_store_word(mstore_o[1]), .mem_req_valid(mvalid_o[1]),
        .mem_req_loaded_word(rdata), .mem_req_fulfilled(f[1]),
        .grant_idx(grant_o[1]), .busy(busy_o[1])
    );

    memory_req_arbiter #(.XLEN(32), .NUM_REQ(2), .ARB_MODE(0)) dut_c (
        .clk(clk), .reset_n(reset_n),
        .up_req_address(addr_c), .up_req_operation(op_c), .up_req_size(size_c),
        .up_req_store_word(store_c), .up_req_valid(valid_c),
        .up_req_loaded_word(lw_c), .up_req_fulfilled(ful_c),
        .mem_req_address(maddr_c), .mem_req_operation(mop_c), .mem_req_size(msize_c),
        .mem_req_store_word(mstore_c), .mem_req_valid(mvalid_c),
        .mem_req_loaded_word(rdata_c), .mem_req_fulfilled(f_c),
        .grant_idx(grant_c), .busy(busy_c)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t e;
    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest expected entry
    always @(negedge clk) begin
        #2;
        if (ful_o[0] != 4'b0) begin
            if (q0.size() == 0) chk("rr_unexpected_pulse", {28'b0, ful_o[0]}, 32'h0);
            else begin
                e = q0.pop_front();
                chk("rr_pulse_onehot", {28'b0, ful_o[0]}, {28'b0, e.onehot});
                chk("rr_loaded_word", lw_o[0], e.data);
            end
        end
        if (ful_o[1] != 4'b0) begin
            if (q1.size() == 0) chk("fp_unexpected_pulse", {28'b0, ful_o[1]}, 32'h0);
            else begin
                e = q1.pop_front();
                chk("fp_pulse_onehot", {28'b0, ful_o[1]}, {28'b0, e.onehot});
                chk("fp_loaded_word", lw_o[1], e.data);
            end
        end
    end

    // One transaction: IDLE cycle, grant, lat BUSY cycles, fulfilled in the last
    task automatic run_vec(input int d, input logic [3:0] mask, input int expg,
                           input int lat, input logic [31:0] data);
        exp_t x;
        @(negedge clk);
        f[0] = 1'b0;
        f[1] = 1'b0;
        valid[1-d] = 4'b0;
        valid[d]   = mask;
        x.onehot = 4'b1 << expg;
        x.data   = data;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
        #1;
        chk("idle_busy", {31'b0, busy_o[d]}, 32'h0);
        chk("idle_valid", {31'b0, mvalid_o[d]}, 32'h0);
        @(negedge clk);
        #1;
        chk("grant_valid", {31'b0, mvalid_o[d]}, 32'h1);
        chk("grant_idx", {30'b0, grant_o[d]}, expg);
        chk("grant_addr", maddr_o[d], addr_tb[expg*32 +: 32]);
        chk("grant_store", mstore_o[d], store_tb[expg*32 +: 32]);
        chk("grant_op", {30'b0, mop_o[d]}, {30'b0, op_tb[expg]});
        chk("grant_size", {30'b0, msize_o[d]}, {30'b0, size_tb[expg]});
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            #1;
            chk("wait_no_pulse", {28'b0, ful_o[d]}, 32'h0);
            chk("wait_addr", maddr_o[d], addr_tb[expg*32 +: 32]);
        end
        rdata = data;
        f[d]  = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            addr_tb[i*32 +: 32]  = 32'h1000 * (i + 1) + 32'h40;
            store_tb[i*32 +: 32] = 32'h5700_0000 + i;
            op_tb[i]   = (i % 2 == 1) ? MEM_OP_STORE : MEM_OP_LOAD;
            size_tb[i] = (i < 2) ? MEM_SIZE_WORD : MEM_SIZE_HALF;
        end
        valid[0] = 4'b0; valid[1] = 4'b0;
        f[0] = 1'b0; f[1] = 1'b0;
        rdata = 32'h0;
        addr_c = 64'h0; store_c = 64'h0;
        op_c[0] = MEM_OP_STORE; op_c[1] = MEM_OP_LOAD;
        size_c[0] = MEM_SIZE_BYTE; size_c[1] = MEM_SIZE_WORD;
        valid_c = 2'b0; f_c = 1'b0; rdata_c = 32'h0;

        //            d  mask     exp lat
        tbl[0]  = '{0, 4'b1111, 0, 1};
        tbl[1]  = '{0, 4'b1111, 1, 1};
        tbl[2]  = '{0, 4'b1111, 2, 1};
        tbl[3]  = '{0, 4'b1111, 3, 1};
        tbl[4]  = '{0, 4'b1111, 0, 1};
        tbl[5]  = '{0, 4'b1111, 1, 1};
        tbl[6]  = '{0, 4'b0001, 0, 2};
        tbl[7]  = '{0, 4'b1000, 3, 3};
        tbl[8]  = '{0, 4'b0110, 1, 1};
        tbl[9]  = '{0, 4'b0110, 2, 2};
        tbl[10] = '{0, 4'b0011, 0, 1};
        tbl[11] = '{0, 4'b1001, 3, 1};
        tbl[12] = '{1, 4'b1010, 1, 1};
        tbl[13] = '{1, 4'b1010, 1, 2};
        tbl[14] = '{1, 4'b1010, 1, 1};
        tbl[15] = '{1, 4'b1000, 3, 1};
        tbl[16] = '{1, 4'b1111, 0, 3};
        tbl[17] = '{1, 4'b1100, 2, 1};
        tbl[18] = '{1, 4'b1110, 1, 1};

        // reset
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", {31'b0, busy_o[d]}, 32'h0);
            chk("rst_valid", {31'b0, mvalid_o[d]}, 32'h0);
            chk("rst_grant", {30'b0, grant_o[d]}, 32'h0);
            chk("rst_addr", maddr_o[d], 32'h0);
            chk("rst_store", mstore_o[d], 32'h0);
            chk("rst_pulse", {28'b0, ful_o[d]}, 32'h0);
        end
        chk("rst_c_valid", {31'b0, mvalid_c}, 32'h0);
        reset_n = 1'b1;

        // two-channel single load on channel 1, fulfilled 3 cycles after valid rises
        @(negedge clk);
        addr_c[63:32] = 32'h1000;
        valid_c = 2'b10;
        #1;
        chk("c_idle_valid", {31'b0, mvalid_c}, 32'h0);
        @(negedge clk);
        #1;
        chk("c_valid_rise", {31'b0, mvalid_c}, 32'h1);
        chk("c_grant", {31'b0, grant_c}, 32'h1);
        chk("c_addr", maddr_c, 32'h1000);
        chk("c_op", {30'b0, mop_c}, {30'b0, MEM_OP_LOAD});
        chk("c_size", {30'b0, msize_c}, {30'b0, MEM_SIZE_WORD});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("c_wait_pulse", {30'b0, ful_c}, 32'h0);
            chk("c_wait_busy", {31'b0, busy_c}, 32'h1);
        end
        @(negedge clk);
        rdata_c = 32'hDEADBEEF;
        f_c = 1'b1;
        #1;
        chk("c_pulse", {30'b0, ful_c}, 32'h2);
        chk("c_loaded", lw_c, 32'hDEADBEEF);
        @(negedge clk);
        f_c = 1'b0;
        valid_c = 2'b00;
        #1;
        chk("c_pulse_end", {30'b0, ful_c}, 32'h0);
        chk("c_busy_end", {31'b0, busy_c}, 32'h0);

        // table: round-robin order/wrap and fixed priority
        for (int i = 0; i < 19; i++) begin
            run_vec(tbl[i].d, tbl[i].mask, tbl[i].exp, tbl[i].lat, 32'hC0DE_0000 + i);
        end
        @(negedge clk);
        f[0] = 1'b0; f[1] = 1'b0;
        valid[0] = 4'b0; valid[1] = 4'b0;

        // mid-BUSY field change and valid drop are ignored (rr_ptr is 0 here)
        @(negedge clk);
        addr_tb[31:0] = 32'h2000;
        valid[0] = 4'b0001;
        e.onehot = 4'b0001;
        e.data   = 32'h000A11CE;
        q0.push_back(e);
        #1;
        chk("stab_idle", {31'b0, busy_o[0]}, 32'h0);
        @(negedge clk);
        #1;
        chk("stab_grant", {30'b0, grant_o[0]}, 32'h0);
        chk("stab_addr0", maddr_o[0], 32'h2000);
        addr_tb[31:0] = 32'h3000;
        valid[0] = 4'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("stab_addr", maddr_o[0], 32'h2000);
            chk("stab_valid", {31'b0, mvalid_o[0]}, 32'h1);
        end
        rdata = 32'h000A11CE;
        f[0] = 1'b1;
        @(negedge clk);
        f[0] = 1'b0;
        #1;
        chk("stab_done", {31'b0, busy_o[0]}, 32'h0);

        // spurious fulfilled while IDLE
        @(negedge clk);
        f[0] = 1'b1;
        #1;
        chk("spur_pulse", {28'b0, ful_o[0]}, 32'h0);
        @(negedge clk);
        #1;
        chk("spur_busy", {31'b0, busy_o[0]}, 32'h0);
        chk("spur_pulse2", {28'b0, ful_o[0]}, 32'h0);
        f[0] = 1'b0;

        // reset mid-BUSY (rr_ptr is 1: channel 2 wins a 0100 request)
        @(negedge clk);
        valid[0] = 4'b0100;
        @(negedge clk);
        #1;
        chk("rmb_busy", {31'b0, busy_o[0]}, 32'h1);
        chk("rmb_grant", {30'b0, grant_o[0]}, 32'h2);
        reset_n = 1'b0;
        valid[0] = 4'b0;
        @(negedge clk);
        #1;
        chk("rmb_valid", {31'b0, mvalid_o[0]}, 32'h0);
        chk("rmb_busy0", {31'b0, busy_o[0]}, 32'h0);
        chk("rmb_grant0", {30'b0, grant_o[0]}, 32'h0);
        reset_n = 1'b1;
        run_vec(0, 4'b1111, 0, 1, 32'hF00D_0001);
        @(negedge clk);
        f[0] = 1'b0;
        valid[0] = 4'b0;
        repeat (2) @(negedge clk);

        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
